// File: rtl/decode_pkg.sv
// decode_pkg: shared control types, ALU opcodes and list helpers for the decode stage
package decode_pkg;

    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_REG_W    = 4;
    localparam int DEF_OFFSET_W = 12;

    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_RSC = 4'b0111;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_CMN = 4'b1011;

    typedef enum logic {RUN, CRACK} state_t;

    typedef enum logic [1:0] {IA, IB, DA, DB} mode_t;

    typedef struct packed {
        logic       pcs;
        logic       regw;
        logic       memtoreg;
        logic       memw;
        logic       branch;
        logic       alusrc;
        logic       byteen;
        logic       blcontrol;
        logic [3:0] alucontrol;
        logic [1:0] flagw;
        logic [1:0] immsrc;
        logic [1:0] regsrc;
    } ctrl_t;

    // arithmetic ops also update C and V, so they get FlagW[0]
    function automatic logic is_arith(input logic [3:0] op);
        return op inside {[ALU_SUB:ALU_RSC], ALU_CMP, ALU_CMN};
    endfunction

    function automatic logic [DEF_REG_W-1:0] lowest_set(input logic [DEF_NUM_REGS-1:0] list);
        lowest_set = '0;
        for (int i = DEF_NUM_REGS - 1; i >= 0; i--)
            if (list[i]) lowest_set = DEF_REG_W'(i);
    endfunction

    function automatic logic [DEF_REG_W:0] popcount(input logic [DEF_NUM_REGS-1:0] list);
        popcount = '0;
        for (int i = 0; i < DEF_NUM_REGS; i++)
            popcount = popcount + {{DEF_REG_W{1'b0}}, list[i]};
    endfunction

endpackage

// File: rtl/decode_core.sv
// decode_core: combinational single-instruction decode of DP, LDR/STR and B/BL
module decode_core
    import decode_pkg::*;
(
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output ctrl_t      ctrl
);

    // map op/funct to control bits; anything unrecognised stays an all-zero NOP
    always_comb begin
        ctrl = '0;
        if (op == 2'b00) begin
            ctrl.regw       = 1'b1;
            ctrl.alusrc     = funct[5];
            ctrl.alucontrol = funct[4:1];
            ctrl.flagw      = {funct[0], funct[0] & is_arith(funct[4:1])};
        end else if (op == 2'b01) begin
            ctrl.alucontrol = ALU_ADD;
            ctrl.alusrc     = ~funct[5];
            ctrl.immsrc     = 2'b01;
            ctrl.regsrc     = {~funct[0], 1'b0};
            ctrl.byteen     = funct[2];
            ctrl.regw       = funct[0];
            ctrl.memw       = ~funct[0];
            ctrl.memtoreg   = funct[0];
        end else if (op == 2'b10 && funct[5]) begin
            ctrl.branch     = 1'b1;
            ctrl.alusrc     = 1'b1;
            ctrl.immsrc     = 2'b10;
            ctrl.regsrc     = 2'b01;
            ctrl.alucontrol = ALU_ADD;
            ctrl.regw       = funct[4];
            ctrl.blcontrol  = funct[4];
        end
        ctrl.pcs = ((rd == 4'hf) & ctrl.regw) | ctrl.branch;
    end

endmodule

// File: rtl/decode_sequencer.sv
// decode_sequencer: registered decode stage that cracks LDM/STM into one uop per cycle
module decode_sequencer
    import decode_pkg::*;
#(
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int REG_W         = DEF_REG_W,
    parameter int OFFSET_W      = DEF_OFFSET_W,
    parameter bit BLOCK_XFER_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [31:0]         Instr,
    input  logic                stall,
    input  logic                flush,
    output logic                instr_ready,
    output logic                uop_valid,
    output logic                PCS,
    output logic                RegW,
    output logic                MemtoReg,
    output logic                MemW,
    output logic                BranchD,
    output logic                ALUSrc,
    output logic                ByteEnableDmem,
    output logic                BLControl,
    output logic [3:0]          ALUControl,
    output logic [1:0]          FlagW,
    output logic [1:0]          ImmSrc,
    output logic [1:0]          RegSrc,
    output logic [REG_W-1:0]    uop_Rn,
    output logic [REG_W-1:0]    uop_Rd,
    output logic [OFFSET_W-1:0] uop_offset,
    output logic                uop_wb,
    output logic [OFFSET_W-1:0] uop_wb_value
);

    state_t               state, state_d;
    mode_t                mode;
    ctrl_t                dec, ctrl_q, ctrl_d;
    logic [NUM_REGS-1:0]  rem, rem_d, list, cur_list, cur_rest;
    logic [OFFSET_W-1:0]  next_off, next_off_d, blk_wbv, blk_wbv_d;
    logic [OFFSET_W-1:0]  four_cnt, start, cur_off, cur_wbv, off_d, wbv_d;
    logic [REG_W-1:0]     blk_rn, blk_rn_d, cur_rn, cur_rd, rn_d, rd_d;
    logic                 blk_l, blk_l_d, blk_w, blk_w_d, cur_l, cur_w;
    logic                 accept, is_blk, blk_first, crack_go, emit_blk, last, nonempty;
    logic                 valid_d, wb_d;
    logic                 unused;

    decode_core u_core (
        .op    (Instr[27:26]),
        .funct (Instr[25:20]),
        .rd    (Instr[15:12]),
        .ctrl  (dec)
    );

    assign instr_ready = (state == RUN) & ~stall;
    assign accept      = instr_valid & instr_ready & ~flush;
    assign is_blk      = BLOCK_XFER_EN && (Instr[27:25] == 3'b100);
    assign list        = Instr[NUM_REGS-1:0];
    assign four_cnt    = OFFSET_W'(popcount(list)) << 2;
    assign mode        = mode_t'({~Instr[23], Instr[24]});
    assign start       = mode == IA ? '0 : mode == IB ? OFFSET_W'(4) :
                         mode == DA ? OFFSET_W'(4) - four_cnt : '0 - four_cnt;
    assign blk_first   = accept & is_blk;
    assign crack_go    = (state == CRACK) & ~stall & ~flush;
    assign emit_blk    = blk_first | crack_go;
    // the first uop comes straight from Instr, later ones from the saved context
    assign cur_list    = blk_first ? list : rem;
    assign cur_rest    = cur_list & (cur_list - NUM_REGS'(1));
    assign cur_rd      = lowest_set(cur_list);
    assign cur_l       = blk_first ? Instr[20] : blk_l;
    assign cur_w       = blk_first ? Instr[21] : blk_w;
    assign cur_rn      = blk_first ? Instr[19:16] : blk_rn;
    assign cur_off     = blk_first ? start : next_off;
    assign cur_wbv     = blk_first ? (Instr[23] ? four_cnt : '0 - four_cnt) : blk_wbv;
    assign last        = cur_rest == '0;
    assign nonempty    = |cur_list;
    assign unused      = ^{Instr[31:28], Instr[22]};

    // state and cracking context
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            rem      <= '0;
            next_off <= '0;
            blk_wbv  <= '0;
            blk_rn   <= '0;
            blk_l    <= 1'b0;
            blk_w    <= 1'b0;
        end else begin
            state    <= state_d;
            rem      <= rem_d;
            next_off <= next_off_d;
            blk_wbv  <= blk_wbv_d;
            blk_rn   <= blk_rn_d;
            blk_l    <= blk_l_d;
            blk_w    <= blk_w_d;
        end
    end

    // stay in CRACK while bits remain; flush abandons the block
    always_comb begin
        state_d    = state;
        rem_d      = rem;
        next_off_d = next_off;
        blk_wbv_d  = blk_wbv;
        blk_rn_d   = blk_rn;
        blk_l_d    = blk_l;
        blk_w_d    = blk_w;
        if (flush) begin
            state_d = RUN;
        end else if (emit_blk) begin
            state_d    = cur_rest != '0 ? CRACK : RUN;
            rem_d      = cur_rest;
            next_off_d = cur_off + OFFSET_W'(4);
            blk_wbv_d  = cur_wbv;
            blk_rn_d   = cur_rn;
            blk_l_d    = cur_l;
            blk_w_d    = cur_w;
        end
    end

    // next uop: plain decode, or a block uop overriding the addressing controls
    always_comb begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        rn_d    = '0;
        rd_d    = '0;
        off_d   = '0;
        wb_d    = 1'b0;
        wbv_d   = '0;
        if (accept && !is_blk) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
            rn_d    = Instr[19:16];
            rd_d    = Instr[15:12];
        end else if (emit_blk) begin
            valid_d           = 1'b1;
            ctrl_d.alusrc     = 1'b1;
            ctrl_d.immsrc     = 2'b01;
            ctrl_d.alucontrol = ALU_ADD;
            ctrl_d.regw       = cur_l & nonempty;
            ctrl_d.memtoreg   = cur_l & nonempty;
            ctrl_d.memw       = ~cur_l & nonempty;
            ctrl_d.pcs        = cur_l & (cur_rd == REG_W'(NUM_REGS - 1));
            rn_d              = cur_rn;
            rd_d              = cur_rd;
            off_d             = cur_off;
            wb_d              = last & cur_w & nonempty;
            wbv_d             = last ? cur_wbv : '0;
        end
    end

    // output register, frozen by stall unless a flush squashes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uop_valid    <= 1'b0;
            ctrl_q       <= '0;
            uop_Rn       <= '0;
            uop_Rd       <= '0;
            uop_offset   <= '0;
            uop_wb       <= 1'b0;
            uop_wb_value <= '0;
        end else if (flush || !stall) begin
            uop_valid    <= valid_d;
            ctrl_q       <= ctrl_d;
            uop_Rn       <= rn_d;
            uop_Rd       <= rd_d;
            uop_offset   <= off_d;
            uop_wb       <= wb_d;
            uop_wb_value <= wbv_d;
        end
    end

    assign PCS            = ctrl_q.pcs;
    assign RegW           = ctrl_q.regw;
    assign MemtoReg       = ctrl_q.memtoreg;
    assign MemW           = ctrl_q.memw;
    assign BranchD        = ctrl_q.branch;
    assign ALUSrc         = ctrl_q.alusrc;
    assign ByteEnableDmem = ctrl_q.byteen;
    assign BLControl      = ctrl_q.blcontrol;
    assign ALUControl     = ctrl_q.alucontrol;
    assign FlagW          = ctrl_q.flagw;
    assign ImmSrc         = ctrl_q.immsrc;
    assign RegSrc         = ctrl_q.regsrc;

endmodule
